// File: rtl/inst_issue.sv
// inst_issue: synchronises and debounces SW_START and captures SW_INST once per debounced press.
// The captured instruction is offered over valid/ready. Define INST_ISSUE_OVERRUN_EN to build the sticky OVERRUN flag.
module inst_issue #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       SW_START,
  input  logic [7:0] SW_INST,
  input  logic       INST_READY,
  output logic       INST_VALID,
  output logic [7:0] INST_OUT,
  output logic       START_LEVEL,
  output logic       OVERRUN
);

  localparam int            CW       = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic {IDLE, PEND} state_e;

  logic          start_meta_q, start_s_q;
  logic [7:0]    inst_meta_q, inst_s_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          level_q, level_d, level_prev_q;
  logic          rise;
  state_e        state_q;
  logic          valid_q;
  logic [7:0]    inst_q;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      start_meta_q <= 1'b0;
      start_s_q    <= 1'b0;
      inst_meta_q  <= 8'h00;
      inst_s_q     <= 8'h00;
    end else begin
      start_meta_q <= SW_START;
      start_s_q    <= start_meta_q;
      inst_meta_q  <= SW_INST;
      inst_s_q     <= inst_meta_q;
    end
  end

  // Level flips only after DEBOUNCE_CYCLES consecutive disagreeing samples.
  always_comb begin
    cnt_d   = cnt_q;
    level_d = level_q;
    if (start_s_q == level_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      cnt_d   = '0;
      level_d = ~level_q;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      cnt_q        <= '0;
      level_q      <= 1'b0;
      level_prev_q <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      level_q      <= level_d;
      level_prev_q <= level_q;
    end
  end

  assign rise = level_q & ~level_prev_q;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= IDLE;
      valid_q <= 1'b0;
      inst_q  <= 8'h00;
    end else begin
      case (state_q)
        IDLE: begin
          if (rise) begin
            inst_q  <= inst_s_q;
            valid_q <= 1'b1;
            state_q <= PEND;
          end
        end
        PEND: begin
          // A press landing on the accept edge becomes the next pending instruction.
          if (INST_READY) begin
            if (rise) begin
              inst_q <= inst_s_q;
            end else begin
              valid_q <= 1'b0;
              state_q <= IDLE;
            end
          end
        end
        default: begin
          state_q <= IDLE;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

`ifdef INST_ISSUE_OVERRUN_EN
  logic overrun_q;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      overrun_q <= 1'b0;
    end else if (state_q == PEND && rise && !INST_READY) begin
      overrun_q <= 1'b1;
    end
  end

  assign OVERRUN = overrun_q;
`else
  assign OVERRUN = 1'b0;
`endif

  assign INST_VALID  = valid_q;
  assign INST_OUT    = inst_q;
  assign START_LEVEL = level_q;

endmodule

// File: doc/inst_issue.md
# inst_issue

Front-end stage that sits directly upstream of the ALU core in `Main`. It turns the raw push-switch `SW_START` and the instruction DIP switches `SW_INST` into a clean, one-instruction-per-press transaction. It synchronises and debounces the start switch, detects its debounced rising edge, and captures the 8-bit instruction (opcode nibble plus immediate nibble). It then presents the instruction to the ALU with a valid/ready handshake.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, default 500000: consecutive stable cycles required to accept a level change. This is 10 ms at a 50 MHz `CLK`. Legal range is 1 or more; the counter width is `$clog2(DEBOUNCE_CYCLES+1)`.

Ports:
- `CLK`  in  1  system clock; all state updates on its rising edge.
- `RST_N`  in  1  asynchronous, active-low reset.
- `SW_START`  in  1  raw start switch; asynchronous and bouncy.
- `SW_INST`  in  8  raw instruction switches: [7:4] opcode, [3:0] immediate.
- `INST_READY`  in  1  the ALU accepts `INST_OUT` on a rising edge where `INST_VALID` and `INST_READY` are both 1.
- `INST_VALID`  out  1  an instruction is pending.
- `INST_OUT`  out  8  the captured instruction; stable while `INST_VALID` is 1.
- `START_LEVEL`  out  1  debounced start level, for LED display.
- `OVERRUN`  out  1  sticky flag: a press occurred while an instruction was still pending.

## Operation
- **Synchroniser.** `SW_START` and all 8 bits of `SW_INST` each pass through a 2-flop synchroniser, giving `start_s` and `inst_s`.
- **Debouncer.** `cnt` clears whenever `start_s` equals `START_LEVEL`. Otherwise `cnt` increments. On the edge where `start_s` still differs and `cnt == DEBOUNCE_CYCLES-1`, `START_LEVEL` toggles and `cnt` clears. Any glitch back to the old level before that edge restarts the count.
- **Edge detection.** A press event `rise` is `START_LEVEL` going 0 to 1, using a registered copy of the previous level.
- **FSM states:**
  - `IDLE`: no instruction pending. On `rise`: capture `INST_OUT <= inst_s`, set `INST_VALID <= 1`, go to `PEND`.
  - `PEND`: `INST_VALID` = 1 and `INST_OUT` is frozen. When `INST_READY` = 1, clear `INST_VALID` and go to `IDLE`. On `rise` without `INST_READY`, set `OVERRUN` (when enabled), drop the new press, and stay in `PEND`.
- **Simultaneous `rise` and `INST_READY` in `PEND`.** The handshake completes and the new press is captured on the same edge: `INST_OUT <= inst_s`, `INST_VALID` stays 1, state stays `PEND`, and `OVERRUN` is unchanged.
- **Holding the switch high** produces exactly one instruction. Re-issue requires a debounced release followed by a debounced press.
- **Switch changes while pending.** `SW_INST` changes while in `PEND` do not affect `INST_OUT`.
- **Reset values.** `INST_VALID`=0, `INST_OUT`=8'h00, `START_LEVEL`=0, `OVERRUN`=0. Synchronisers, `cnt` and the FSM (`IDLE`) also reset.
- **Reset mid-operation.** A pending instruction is discarded.
- **Switch held high through reset.** If `SW_START` is high at reset release, it debounces to 1 and issues one instruction.

## Timing
- **Latency.** For a clean `SW_START` 0 to 1 transition, `START_LEVEL` rises at edge 2+`DEBOUNCE_CYCLES` after the input change, and `INST_VALID` rises at edge 3+`DEBOUNCE_CYCLES`.
- **Capture point.** `INST_OUT` is sampled from `inst_s` at that edge, so `SW_INST` must be stable at least 2 cycles before it.
- **Release.** The release path has the same latency on `START_LEVEL`; it has no output effect except re-arming.
- **Acceptance.** `INST_VALID` falls on the same edge where `INST_READY` is sampled high. There is no combinational path from `INST_READY` to any output.
- **Throughput.** At most one instruction per debounced press, plus one handshake cycle.

## Configuration
- `INST_ISSUE_OVERRUN_EN` defined: the `OVERRUN` sticky flag is implemented as described and cleared only by `RST_N`.
- Not defined: `OVERRUN` is tied to 0, no overrun logic is built, and dropped presses are silent. All other behaviour is identical.

## Test plan
All scenarios use `DEBOUNCE_CYCLES`=4 and a 20 ns `CLK`.
1. **Clean press.** After reset, set `SW_INST`=8'h11 and raise `SW_START` -> `INST_VALID` rises at edge 7 with `INST_OUT`=8'h11. Hold `INST_READY`=1 for one cycle -> `INST_VALID`=0 on that edge.
2. **Bounce rejection.** Toggle `SW_START` 1/0 every 2 cycles for 20 cycles, then hold 1 -> exactly one instruction, issued at edge 7 after the final stable 1. `START_LEVEL` shows no glitches.
3. **Held switch.** Press once with `SW_INST`=8'h53 and accept it; keep `SW_START`=1 for 100 cycles while changing `SW_INST` to 8'h73 -> no second `INST_VALID`. Release, then press again -> `INST_OUT`=8'h73.
4. **Overrun.** Keep `INST_READY`=0. Press (8'h80), release, then press (8'h99) -> `INST_OUT` stays 8'h80 and `OVERRUN`=1 (0 when the macro is undefined). Accepting the instruction clears `INST_VALID`; `OVERRUN` stays 1.
5. **Simultaneous events.** Arrange for the second press's `rise` edge to coincide with `INST_READY`=1 -> `INST_VALID` stays 1, `INST_OUT` takes the new value, and `OVERRUN`=0.
6. **Reset mid-operation.** Pulse `RST_N` low for 3 ns while in `PEND` -> all outputs are 0 immediately. With `SW_START` held at 1, a fresh instruction issues at edge 7 after reset release.
